// File: rtl/dr_shift_bank.sv
// dr_shift_bank
//   Bank of four JTAG data registers (bypass, IDCODE, boundary scan, BIST)
//   feeding the DR select mux. Capture/shift/update strobes from the TAP
//   controller act only on the register chosen by DR_Sel. When strobes
//   overlap on an edge, only the highest-priority one acts:
//   capture > shift > update.
//
// Ports
//   TCK          test clock, rising-edge active
//   Reset        asynchronous active-high reset
//   TDI          serial data in
//   DR_Sel       00 bypass, 01 IDCODE, 10 boundary scan, 11 BIST
//   Capture_DR   capture strobe (one TCK)
//   Shift_DR     shift enable (level)
//   Update_DR    update strobe (one TCK)
//   BS_pin_in    parallel pin values captured into the BS DR
//   BIST_status  parallel status captured into the BIST DR
//   BP_reg       bypass DR serial out
//   ID_reg       IDCODE DR serial out (bit 0)
//   BS_reg       BS DR serial out (bit 0)
//   BIST_reg     BIST DR serial out (bit 0)
//   BS_update    BS update latch
//   BIST_ctrl    BIST update latch
module dr_shift_bank #(
  parameter logic [31:0] IDCODE   = 32'h1234_5093,
  parameter int          BS_LEN   = 8,
  parameter int          BIST_LEN = 8
) (
  input  logic                TCK,
  input  logic                Reset,
  input  logic                TDI,
  input  logic [1:0]          DR_Sel,
  input  logic                Capture_DR,
  input  logic                Shift_DR,
  input  logic                Update_DR,
  input  logic [BS_LEN-1:0]   BS_pin_in,
  input  logic [BIST_LEN-1:0] BIST_status,
  output logic                BP_reg,
  output logic                ID_reg,
  output logic                BS_reg,
  output logic                BIST_reg,
  output logic [BS_LEN-1:0]   BS_update,
  output logic [BIST_LEN-1:0] BIST_ctrl
);

  localparam logic [1:0] SEL_BP   = 2'b00;
  localparam logic [1:0] SEL_ID   = 2'b01;
  localparam logic [1:0] SEL_BS   = 2'b10;
  localparam logic [1:0] SEL_BIST = 2'b11;

  logic                bp_q;
  logic [31:0]         id_q;
  logic [BS_LEN-1:0]   bs_q;
  logic [BIST_LEN-1:0] bist_q;

  always_ff @(posedge TCK or posedge Reset) begin
    if (Reset) begin
      bp_q      <= 1'b0;
      id_q      <= IDCODE;
      bs_q      <= '0;
      bist_q    <= '0;
      BS_update <= '0;
      BIST_ctrl <= '0;
    end else if (Capture_DR) begin
      case (DR_Sel)
        SEL_BP:   bp_q   <= 1'b0;
        SEL_ID:   id_q   <= IDCODE;
        SEL_BS:   bs_q   <= BS_pin_in;
        SEL_BIST: bist_q <= BIST_status;
        default:  ;
      endcase
    end else if (Shift_DR) begin
      // LSB-first: TDI enters at the MSB, serial out is bit 0
      case (DR_Sel)
        SEL_BP:   bp_q   <= TDI;
        SEL_ID:   id_q   <= {TDI, id_q[31:1]};
        SEL_BS:   bs_q   <= {TDI, bs_q[BS_LEN-1:1]};
        SEL_BIST: bist_q <= {TDI, bist_q[BIST_LEN-1:1]};
        default:  ;
      endcase
    end else if (Update_DR) begin
      // bypass and IDCODE have no update latch
      case (DR_Sel)
        SEL_BS:   BS_update <= bs_q;
        SEL_BIST: BIST_ctrl <= bist_q;
        default:  ;
      endcase
    end
  end

  // All serial outputs come straight from flops
  assign BP_reg   = bp_q;
  assign ID_reg   = id_q[0];
  assign BS_reg   = bs_q[0];
  assign BIST_reg = bist_q[0];

endmodule

// File: tb/tb_dr_shift_bank.sv
module tb_dr_shift_bank;

  localparam logic [31:0] IDC = 32'h1234_5093;

  logic       TCK = 1'b0;
  logic       Reset = 1'b0;
  logic       TDI = 1'b0;
  logic [1:0] DR_Sel = 2'b00;
  logic       Capture_DR = 1'b0, Shift_DR = 1'b0, Update_DR = 1'b0;
  logic [7:0] BS_pin_in = 8'h00, BIST_status = 8'h00;
  logic       BP_reg, ID_reg, BS_reg, BIST_reg;
  logic [7:0] BS_update, BIST_ctrl;

  dr_shift_bank #(.IDCODE(IDC), .BS_LEN(8), .BIST_LEN(8)) dut (
    .TCK(TCK), .Reset(Reset), .TDI(TDI), .DR_Sel(DR_Sel),
    .Capture_DR(Capture_DR), .Shift_DR(Shift_DR), .Update_DR(Update_DR),
    .BS_pin_in(BS_pin_in), .BIST_status(BIST_status),
    .BP_reg(BP_reg), .ID_reg(ID_reg), .BS_reg(BS_reg), .BIST_reg(BIST_reg),
    .BS_update(BS_update), .BIST_ctrl(BIST_ctrl)
  );

  bit clk_run = 1'b0;
  always begin
    #5;
    if (clk_run) TCK = ~TCK;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: each DR is a queue of bits, element 0 is the serial-out end.
  bit         bp_m;
  bit         id_m[$];
  bit         bs_m[$];
  bit         bist_m[$];
  logic [7:0] bsu_m, bc_m;

  task automatic m_reset();
    logic [31:0] v;
    v = IDC;
    bp_m = 1'b0;
    id_m.delete(); bs_m.delete(); bist_m.delete();
    for (int i = 0; i < 32; i++) id_m.push_back(v[i]);
    for (int i = 0; i < 8; i++) begin bs_m.push_back(1'b0); bist_m.push_back(1'b0); end
    bsu_m = 8'h00;
    bc_m  = 8'h00;
  endtask

  task automatic m_edge(input logic [1:0] sel, input bit cap, input bit sh, input bit upd,
                        input bit tdi, input logic [7:0] pins, input logic [7:0] st);
    logic [31:0] v;
    v = IDC;
    if (cap) begin
      if (sel == 0) bp_m = 1'b0;
      else if (sel == 1) begin id_m.delete(); for (int i = 0; i < 32; i++) id_m.push_back(v[i]); end
      else if (sel == 2) begin bs_m.delete(); for (int i = 0; i < 8; i++) bs_m.push_back(pins[i]); end
      else begin bist_m.delete(); for (int i = 0; i < 8; i++) bist_m.push_back(st[i]); end
    end else if (sh) begin
      if (sel == 0) bp_m = tdi;
      else if (sel == 1) begin void'(id_m.pop_front()); id_m.push_back(tdi); end
      else if (sel == 2) begin void'(bs_m.pop_front()); bs_m.push_back(tdi); end
      else begin void'(bist_m.pop_front()); bist_m.push_back(tdi); end
    end else if (upd) begin
      if (sel == 2) for (int i = 0; i < 8; i++) bsu_m[i] = bs_m[i];
      else if (sel == 3) for (int i = 0; i < 8; i++) bc_m[i] = bist_m[i];
    end
  endtask

  task automatic m_check(input string tag);
    chk({tag, ".BP_reg"},    {31'd0, BP_reg},   {31'd0, bp_m});
    chk({tag, ".ID_reg"},    {31'd0, ID_reg},   {31'd0, id_m[0]});
    chk({tag, ".BS_reg"},    {31'd0, BS_reg},   {31'd0, bs_m[0]});
    chk({tag, ".BIST_reg"},  {31'd0, BIST_reg}, {31'd0, bist_m[0]});
    chk({tag, ".BS_update"}, {24'd0, BS_update}, {24'd0, bsu_m});
    chk({tag, ".BIST_ctrl"}, {24'd0, BIST_ctrl}, {24'd0, bc_m});
  endtask

  // Drive inputs, take one rising edge, advance the model, compare 1 ns later.
  task automatic step(input logic [1:0] sel, input bit cap, input bit sh, input bit upd,
                      input bit tdi, input logic [7:0] pins, input logic [7:0] st,
                      input string tag);
    DR_Sel = sel; Capture_DR = cap; Shift_DR = sh; Update_DR = upd;
    TDI = tdi; BS_pin_in = pins; BIST_status = st;
    @(posedge TCK);
    m_edge(sel, cap, sh, upd, tdi, pins, st);
    #1;
    m_check(tag);
  endtask

  typedef struct {
    logic [1:0] sel;
    bit         cap, sh, upd, tdi;
    logic [7:0] pins, st;
    bit         e_bp, e_bs, e_bist;
    logic [7:0] e_bsu, e_bc;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic [1:0] sel, bit cap, bit sh, bit upd, bit tdi,
                              logic [7:0] pins, logic [7:0] st,
                              bit e_bp, bit e_bs, bit e_bist, logic [7:0] e_bsu, logic [7:0] e_bc);
    vec_t v;
    v.sel = sel; v.cap = cap; v.sh = sh; v.upd = upd; v.tdi = tdi;
    v.pins = pins; v.st = st;
    v.e_bp = e_bp; v.e_bs = e_bs; v.e_bist = e_bist; v.e_bsu = e_bsu; v.e_bc = e_bc;
    return v;
  endfunction

  initial begin
    logic [31:0] idv;
    bit bs_tdi[8];
    bit bi_tdi[8];
    bs_tdi = '{0, 0, 1, 1, 1, 1, 0, 0};   // 8'h3C LSB first
    bi_tdi = '{0, 1, 0, 1, 1, 0, 1, 0};   // 8'h5A LSB first
    idv = IDC;

    // Bypass: capture then shift 1,0,1,1
    vt.push_back(mk(2'b00, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00));
    vt.push_back(mk(2'b00, 0, 1, 0, 1, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00));
    vt.push_back(mk(2'b00, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00));
    vt.push_back(mk(2'b00, 0, 1, 0, 1, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00));
    vt.push_back(mk(2'b00, 0, 1, 0, 1, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00));
    // BS: capture A5, shift 3C in, update
    vt.push_back(mk(2'b10, 1, 0, 0, 0, 8'hA5, 8'h00, 1, 1, 0, 8'h00, 8'h00));
    vt.push_back(mk(2'b10, 0, 1, 0, bs_tdi[0], 8'hA5, 8'h00, 1, 0, 0, 8'h00, 8'h00));
    vt.push_back(mk(2'b10, 0, 1, 0, bs_tdi[1], 8'hA5, 8'h00, 1, 1, 0, 8'h00, 8'h00));
    vt.push_back(mk(2'b10, 0, 1, 0, bs_tdi[2], 8'hA5, 8'h00, 1, 0, 0, 8'h00, 8'h00));
    vt.push_back(mk(2'b10, 0, 1, 0, bs_tdi[3], 8'hA5, 8'h00, 1, 0, 0, 8'h00, 8'h00));
    vt.push_back(mk(2'b10, 0, 1, 0, bs_tdi[4], 8'hA5, 8'h00, 1, 1, 0, 8'h00, 8'h00));
    vt.push_back(mk(2'b10, 0, 1, 0, bs_tdi[5], 8'hA5, 8'h00, 1, 0, 0, 8'h00, 8'h00));
    vt.push_back(mk(2'b10, 0, 1, 0, bs_tdi[6], 8'hA5, 8'h00, 1, 1, 0, 8'h00, 8'h00));
    vt.push_back(mk(2'b10, 0, 1, 0, bs_tdi[7], 8'hA5, 8'h00, 1, 0, 0, 8'h00, 8'h00));
    vt.push_back(mk(2'b10, 0, 0, 1, 0, 8'hA5, 8'h00, 1, 0, 0, 8'h3C, 8'h00));
    // BIST: shift 5A in, update
    for (int i = 0; i < 8; i++)
      vt.push_back(mk(2'b11, 0, 1, 0, bi_tdi[i], 8'h00, 8'h00, 1, 0, 0, 8'h3C, 8'h00));
    vt.push_back(mk(2'b11, 0, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 8'h3C, 8'h5A));
    // Capture beats update; shift beats update; update on bypass is inert
    vt.push_back(mk(2'b11, 1, 0, 1, 0, 8'h00, 8'hC3, 1, 0, 1, 8'h3C, 8'h5A));
    vt.push_back(mk(2'b11, 0, 1, 1, 1, 8'h00, 8'hC3, 1, 0, 1, 8'h3C, 8'h5A));
    vt.push_back(mk(2'b00, 0, 0, 1, 0, 8'h00, 8'h00, 1, 0, 1, 8'h3C, 8'h5A));

    // Reset pulse with the clock stopped
    #2 Reset = 1'b1;
    #3 Reset = 1'b0;
    m_reset();
    #1;
    chk("rst.BP_reg",    {31'd0, BP_reg},   32'd0);
    chk("rst.ID_reg",    {31'd0, ID_reg},   {31'd0, idv[0]});
    chk("rst.BS_reg",    {31'd0, BS_reg},   32'd0);
    chk("rst.BIST_reg",  {31'd0, BIST_reg}, 32'd0);
    chk("rst.BS_update", {24'd0, BS_update}, 32'd0);
    chk("rst.BIST_ctrl", {24'd0, BIST_ctrl}, 32'd0);
    clk_run = 1'b1;
    @(negedge TCK);

    foreach (vt[i]) begin
      step(vt[i].sel, vt[i].cap, vt[i].sh, vt[i].upd, vt[i].tdi, vt[i].pins, vt[i].st,
           $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.BP_reg", i),    {31'd0, BP_reg},   {31'd0, vt[i].e_bp});
      chk($sformatf("vec%0d.BS_reg", i),    {31'd0, BS_reg},   {31'd0, vt[i].e_bs});
      chk($sformatf("vec%0d.BIST_reg", i),  {31'd0, BIST_reg}, {31'd0, vt[i].e_bist});
      chk($sformatf("vec%0d.BS_update", i), {24'd0, BS_update}, {24'd0, vt[i].e_bsu});
      chk($sformatf("vec%0d.BIST_ctrl", i), {24'd0, BIST_ctrl}, {24'd0, vt[i].e_bc});
    end

    // IDCODE capture then 32 zero shifts: ID_reg walks the code LSB first
    step(2'b01, 1, 0, 0, 0, 8'h00, 8'h00, "id.cap");
    chk("id.cap.ID_reg", {31'd0, ID_reg}, {31'd0, idv[0]});
    for (int k = 1; k <= 32; k++) begin
      step(2'b01, 0, 1, 0, 0, 8'h00, 8'h00, $sformatf("id.sh%0d", k));
      chk($sformatf("id.sh%0d.ID_reg", k), {31'd0, ID_reg}, (k < 32) ? {31'd0, idv[k]} : 32'd0);
    end

    // Async reset four bits into shifting FF through BS
    for (int k = 0; k < 4; k++) step(2'b10, 0, 1, 0, 1, 8'h00, 8'h00, $sformatf("ar.sh%0d", k));
    @(negedge TCK);
    #2 Reset = 1'b1;
    #1;
    m_reset();
    chk("ar.BS_reg",    {31'd0, BS_reg},   32'd0);
    chk("ar.BS_update", {24'd0, BS_update}, 32'd0);
    chk("ar.BIST_ctrl", {24'd0, BIST_ctrl}, 32'd0);
    chk("ar.ID_reg",    {31'd0, ID_reg},   {31'd0, idv[0]});
    @(negedge TCK);
    Reset = 1'b0;
    for (int k = 0; k < 8; k++) step(2'b10, 0, 1, 0, 1, 8'h00, 8'h00, $sformatf("ar.re%0d", k));
    step(2'b10, 0, 0, 1, 0, 8'h00, 8'h00, "ar.upd");
    chk("ar.upd.BS_update", {24'd0, BS_update}, 32'h0000_00FF);

    // Randomized traffic against the model, including selection changes mid-shift
    for (int n = 0; n < 400; n++) begin
      logic [1:0] s;
      bit c, sh, u, t;
      s  = 2'($urandom_range(0, 3));
      c  = ($urandom_range(0, 7) == 0);
      sh = ($urandom_range(0, 1) == 1);
      u  = ($urandom_range(0, 5) == 0);
      t  = 1'($urandom);
      step(s, c, sh, u, t, 8'($urandom), 8'($urandom), $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
